// File: rtl/scoreboard_reg_file.sv
// Decode-stage register file with busy scoreboard.
// Two registered read ports with write bypass, stall hold, one write port.
module scoreboard_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_flag,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              hazard1,
    output logic              hazard2,
    input  logic              reg_wr,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    output logic [ADDR_W:0]   busy_count
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] LIM = NUM_REGS[ADDR_W:0];

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    function automatic logic is_valid(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < LIM) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    logic              wr_ok, rv_ok;
    logic              byp1, byp2;
    logic [DATA_W-1:0] nd1, nd2;
    logic              nh1, nh2;
    logic              inc, dec;

    assign wr_ok = reg_wr && is_valid(reg_wr_addr);
    assign rv_ok = resv_en && is_valid(resv_addr);
    assign byp1  = wr_ok && (reg_wr_addr == rd_addr1);
    assign byp2  = wr_ok && (reg_wr_addr == rd_addr2);

    always_comb begin
        nd1 = '0;
        nh1 = 1'b0;
        if (is_valid(rd_addr1)) begin
            nd1 = byp1 ? reg_wr_data : regs[idx(rd_addr1)];
            nh1 = busy[idx(rd_addr1)] && !byp1;
        end
    end

    always_comb begin
        nd2 = '0;
        nh2 = 1'b0;
        if (is_valid(rd_addr2)) begin
            nd2 = byp2 ? reg_wr_data : regs[idx(rd_addr2)];
            nh2 = busy[idx(rd_addr2)] && !byp2;
        end
    end

    // A reservation and a clearing write to the same register cancel out.
    assign inc = rv_ok && !busy[idx(resv_addr)];
    assign dec = wr_ok && busy[idx(reg_wr_addr)]
                 && !(rv_ok && (resv_addr == reg_wr_addr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[idx(reg_wr_addr)] <= reg_wr_data;
        end
    end

    // Reservation is assigned last so it wins over a same-address write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_ok) begin
                busy[idx(reg_wr_addr)] <= 1'b0;
            end
            if (rv_ok) begin
                busy[idx(resv_addr)] <= 1'b1;
            end
            if (inc && !dec) begin
                busy_count <= busy_count + 1'b1;
            end else if (dec && !inc) begin
                busy_count <= busy_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            hazard1  <= 1'b0;
            hazard2  <= 1'b0;
        end else if (!stall_flag) begin
            rd_data1 <= nd1;
            rd_data2 <= nd2;
            hazard1  <= nh1;
            hazard2  <= nh2;
        end
    end

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench for scoreboard_reg_file.
// Second instance with NUM_REGS=16 covers out-of-range reads.
module tb_scoreboard_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_flag;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        reg_wr;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        resv_en;
    logic [4:0]  resv_addr;

    logic [31:0] rd_data1, rd_data2;
    logic        hazard1, hazard2;
    logic [5:0]  busy_count;

    logic [31:0] s_data1, s_data2;
    logic        s_haz1, s_haz2;
    logic [5:0]  s_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scoreboard_reg_file dut (
        .clk(clk), .reset(reset), .stall_flag(stall_flag),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .hazard1(hazard1), .hazard2(hazard2),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .busy_count(busy_count)
    );

    scoreboard_reg_file #(.NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset), .stall_flag(stall_flag),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(s_data1), .rd_data2(s_data2),
        .hazard1(s_haz1), .hazard2(s_haz2),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .busy_count(s_count)
    );

    task automatic idle();
        stall_flag  = 1'b0;
        reg_wr      = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        resv_en     = 1'b0;
        resv_addr   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;
        idle();
        #2 reset = 1'b0;
        #1;
        total++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got %h %h want 0 0",
                     rd_data1, rd_data2);
        end
        total++;
        if (hazard1 !== 1'b0 || hazard2 !== 1'b0 || busy_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_flags: got h=%b%b cnt=%0d want 00 0",
                     hazard1, hazard2, busy_count);
        end
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        idle();
        reg_wr = 1'b1; reg_wr_addr = 5'd5; reg_wr_data = 32'hA5;
        tick();
        idle();
        rd_addr1 = 5'd5;
        tick();
        total++;
        if (rd_data1 !== 32'hA5) begin
            bad++;
            $display("FAIL read_latency: got %h want 000000a5", rd_data1);
        end
        reg_wr = 1'b1; reg_wr_addr = 5'd7; reg_wr_data = 32'h77;
        rd_addr2 = 5'd7;
        tick();
        idle();
        total++;
        if (rd_data2 !== 32'h77 || hazard2 !== 1'b0) begin
            bad++;
            $display("FAIL bypass: got %h h=%b want 00000077 h=0",
                     rd_data2, hazard2);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        reg_wr = 1'b1; reg_wr_addr = 5'd0; reg_wr_data = 32'hFFFF_FFFF;
        resv_en = 1'b1; resv_addr = 5'd0;
        rd_addr2 = 5'd0;
        tick();
        idle();
        total++;
        if (rd_data2 !== 32'h0) begin
            bad++;
            $display("FAIL zero_bypass: got %h want 0", rd_data2);
        end
        rd_addr1 = 5'd0;
        tick();
        total++;
        if (rd_data1 !== 32'h0 || hazard1 !== 1'b0 || busy_count !== 6'd0) begin
            bad++;
            $display("FAIL zero_reg: got %h h=%b cnt=%0d want 0 h=0 cnt=0",
                     rd_data1, hazard1, busy_count);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        resv_en = 1'b1; resv_addr = 5'd3;
        rd_addr1 = 5'd3;
        tick();
        idle();
        total++;
        if (busy_count !== 6'd1 || hazard1 !== 1'b0) begin
            bad++;
            $display("FAIL resv_count: got cnt=%0d h=%b want cnt=1 h=0",
                     busy_count, hazard1);
        end
        tick();
        total++;
        if (hazard1 !== 1'b1) begin
            bad++;
            $display("FAIL hazard_set: got %b want 1", hazard1);
        end
        reg_wr = 1'b1; reg_wr_addr = 5'd3; reg_wr_data = 32'h33;
        tick();
        idle();
        total++;
        if (rd_data1 !== 32'h33 || hazard1 !== 1'b0 || busy_count !== 6'd0) begin
            bad++;
            $display("FAIL writeback: got %h h=%b cnt=%0d want 33 h=0 cnt=0",
                     rd_data1, hazard1, busy_count);
        end
    endtask

    task automatic test_resv_write();
        idle();
        resv_en = 1'b1; resv_addr = 5'd9;
        tick();
        resv_addr = 5'd11;
        tick();
        idle();
        total++;
        if (busy_count !== 6'd2) begin
            bad++;
            $display("FAIL two_resv: got %0d want 2", busy_count);
        end
        reg_wr = 1'b1; reg_wr_addr = 5'd9; reg_wr_data = 32'h99;
        resv_en = 1'b1; resv_addr = 5'd9;
        tick();
        idle();
        total++;
        if (busy_count !== 6'd2) begin
            bad++;
            $display("FAIL same_addr_cnt: got %0d want 2", busy_count);
        end
        rd_addr1 = 5'd9;
        tick();
        total++;
        if (rd_data1 !== 32'h99 || hazard1 !== 1'b1) begin
            bad++;
            $display("FAIL same_addr_rd: got %h h=%b want 99 h=1",
                     rd_data1, hazard1);
        end
        reg_wr = 1'b1; reg_wr_addr = 5'd11; reg_wr_data = 32'hB1;
        resv_en = 1'b1; resv_addr = 5'd10;
        tick();
        idle();
        total++;
        if (busy_count !== 6'd2) begin
            bad++;
            $display("FAIL net_zero: got %0d want 2", busy_count);
        end
        rd_addr1 = 5'd10;
        rd_addr2 = 5'd11;
        tick();
        total++;
        if (hazard1 !== 1'b1 || hazard2 !== 1'b0 || rd_data2 !== 32'hB1) begin
            bad++;
            $display("FAIL net_zero_rd: got h=%b%b d2=%h want h=10 d2=b1",
                     hazard1, hazard2, rd_data2);
        end
    endtask

    task automatic test_stall();
        idle();
        reg_wr = 1'b1; reg_wr_addr = 5'd1; reg_wr_data = 32'h12;
        tick();
        idle();
        rd_addr1 = 5'd1;
        tick();
        stall_flag = 1'b1;
        reg_wr = 1'b1; reg_wr_addr = 5'd1; reg_wr_data = 32'h99;
        resv_en = 1'b1; resv_addr = 5'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            resv_en = 1'b0;
            total++;
            if (rd_data1 !== 32'h12) begin
                bad++;
                $display("FAIL stall_hold%0d: got %h want 12", i, rd_data1);
            end
        end
        total++;
        if (busy_count !== 6'd3) begin
            bad++;
            $display("FAIL stall_count: got %0d want 3", busy_count);
        end
        idle();
        tick();
        total++;
        if (rd_data1 !== 32'h99) begin
            bad++;
            $display("FAIL stall_release: got %h want 99", rd_data1);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        #2 reset = 1'b0;
        #1;
        total++;
        if (rd_data1 !== 32'h0 || busy_count !== 6'd0 || hazard1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got %h cnt=%0d h=%b want 0 0 0",
                     rd_data1, busy_count, hazard1);
        end
        #2 reset = 1'b1;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd9;
        tick();
        total++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || hazard2 !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: got %h %h h2=%b want 0 0 h2=0",
                     rd_data1, rd_data2, hazard2);
        end
        rd_addr1 = 5'd4;
        tick();
        total++;
        if (rd_data1 !== 32'h0 || hazard1 !== 1'b0) begin
            bad++;
            $display("FAIL read_r4: got %h h=%b want 0 h=0",
                     rd_data1, hazard1);
        end
    endtask

    task automatic test_out_of_range();
        idle();
        reg_wr = 1'b1; reg_wr_addr = 5'd20; reg_wr_data = 32'hDEAD;
        resv_en = 1'b1; resv_addr = 5'd20;
        rd_addr1 = 5'd20;
        tick();
        idle();
        total++;
        if (s_data1 !== 32'h0 || s_haz1 !== 1'b0 || s_count !== 6'd0) begin
            bad++;
            $display("FAIL oor_bypass: got %h h=%b cnt=%0d want 0 0 0",
                     s_data1, s_haz1, s_count);
        end
        total++;
        if (busy_count !== 6'd1) begin
            bad++;
            $display("FAIL r20_count: got %0d want 1", busy_count);
        end
        tick();
        total++;
        if (s_data1 !== 32'h0 || s_haz1 !== 1'b0) begin
            bad++;
            $display("FAIL oor_read: got %h h=%b want 0 h=0", s_data1, s_haz1);
        end
        total++;
        if (rd_data1 !== 32'hDEAD || hazard1 !== 1'b1) begin
            bad++;
            $display("FAIL r20_read: got %h h=%b want dead h=1",
                     rd_data1, hazard1);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_zero_reg();
        test_scoreboard();
        test_resv_write();
        test_stall();
        test_mid_reset();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scoreboard_reg_file.md
Name: scoreboard_reg_file

Overview:
- Parametrised successor to the decode-stage register file: configurable width, depth and zero-register mode.
- Two registered read ports with write-to-read bypass and stall hold; one write port.
- Per-register busy scoreboard: decode reserves a destination, writeback clears it, and read ports flag hazards.
- Sits in decode; feeds operand latches and the stall controller.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, implemented registers (≤ 2**ADDR_W)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous active-low reset
stall_flag  input  1  1 = hold read outputs
rd_addr1  input  ADDR_W  read port 1 address
rd_addr2  input  ADDR_W  read port 2 address
rd_data1  output  DATA_W  registered read data, port 1
rd_data2  output  DATA_W  registered read data, port 2
hazard1  output  1  registered: port 1 source busy
hazard2  output  1  registered: port 2 source busy
reg_wr  input  1  writeback enable
reg_wr_addr  input  ADDR_W  writeback address
reg_wr_data  input  DATA_W  writeback data
resv_en  input  1  reserve destination (decode issue)
resv_addr  input  ADDR_W  destination to mark busy
busy_count  output  ADDR_W+1  number of busy registers

Behaviour:
- Reset (reset==0, asynchronous, no clock needed): all registers 0, all busy bits 0, rd_data1/2=0, hazard1/2=0, busy_count=0. A reset mid-operation discards pending reservations. The first posedge after reset deasserts behaves as a normal cycle.
- Address validity:
  - "Valid" means addr < NUM_REGS and not (ZERO_REG and addr==0).
  - A write or reservation to an invalid address is ignored.
  - A read of an invalid address returns 0 with hazard 0.
- Write: on posedge, if reg_wr and the address is valid, regs[reg_wr_addr] <= reg_wr_data and busy[reg_wr_addr] <= 0.
- Reserve: on posedge, if resv_en and the address is valid, busy[resv_addr] <= 1.
- Write and reserve to the same address in the same cycle: the data is written and busy ends at 1 (reservation wins; a new producer has been issued).
- Read, per port n, latency 1 cycle:
  - On posedge with stall_flag==0: rd_datan <= bypass value; hazardn <= busy[rd_addrn] && !(reg_wr && reg_wr_addr==rd_addrn).
  - Bypass value is reg_wr_data when reg_wr and reg_wr_addr==rd_addrn (valid address); otherwise regs[rd_addrn].
  - Hazard uses the busy state before this edge. A reservation in the same cycle does not raise hazard for the same-cycle read.
  - With stall_flag==1: rd_data and hazard hold their values. Writes, reservations and busy_count still update while stalled.
- busy_count:
  - Registered; equals the population count of busy bits after the edge.
  - Per cycle it changes by at most +1/−1: +1 for a reservation of a not-busy register; −1 for a write clearing a busy register with no same-address reservation; a write and reservation to different addresses net to zero.
  - Range 0..NUM_REGS; never wraps.
- Both read ports may address the same register; each port resolves independently.
- No combinational path from any input to any output.

Test Plan:
- Reset values: drive reset=0 mid-run after writes → all outputs 0 immediately. After release, reading r4 → 0, hazard 0.
- Write/read latency: write r5=0x0000_00A5, then in the next cycle read rd_addr1=5 → rd_data1=0xA5 one cycle later. Same-cycle write r7=0x77 with read rd_addr2=7 → rd_data2=0x77 (bypass).
- Zero register: ZERO_REG=1, write r0=0xFFFF_FFFF with resv_en r0 → read r0 gives 0, hazard1=0, busy_count unchanged.
- Scoreboard: resv r3 → busy_count=1. Read r3 next cycle → hazard1=1. Writeback r3=0x33 with a same-cycle read → rd_data1=0x33, hazard1=0, busy_count=0.
- Simultaneous reserve+write r9 → data written, busy stays 1, busy_count unchanged. Reserve r10 while writing busy r11 → busy_count unchanged.
- Stall hold: rd_data1=0x12 with stall_flag=1 for 3 cycles, while r1 is written to 0x99 → rd_data1 stays 0x12. Deassert stall → 0x99 after one edge. Out-of-range read with NUM_REGS=16, addr 20 → 0, hazard 0.
